// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared command and piece types for the tetris datapath
package tetris_pkg;

    typedef logic [1:0] command_t;

    typedef enum logic [2:0] {
        HERO           = 3'd0,
        SMASH_BOY      = 3'd1,
        TEEWEE         = 3'd2,
        ORANGE_RICKY   = 3'd3,
        BLUE_RICKY     = 3'd4,
        RHODE_ISLAND_Z = 3'd5,
        CLEVELAND_Z    = 3'd6
    } active_piece_t;

    // Select code 7 has no piece of its own and falls back to HERO.
    function automatic active_piece_t decode_piece(input logic [2:0] sel);
        active_piece_t piece;
        case (sel)
            3'd1:    piece = SMASH_BOY;
            3'd2:    piece = TEEWEE;
            3'd3:    piece = ORANGE_RICKY;
            3'd4:    piece = BLUE_RICKY;
            3'd5:    piece = RHODE_ISLAND_Z;
            3'd6:    piece = CLEVELAND_Z;
            default: piece = HERO;
        endcase
        return piece;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - synchronous FIFO holding queued player moves
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full queue still lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - arbitrates SPI move bytes and gravity ticks into one command stream
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int FIFO_DEPTH            = 4,
    parameter int TELEMETRY_VALUE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       spi_data,
    input  logic                             spi_data_valid,
    output logic                             spi_clear,
    input  logic                             game_tick,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic                             cmd_is_gravity,
    output command_t                         cmd_move,
    output active_piece_t                    new_piece,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic [TELEMETRY_VALUE_WIDTH-1:0] overflow_count,
    output logic [TELEMETRY_VALUE_WIDTH-1:0] missed_tick_count
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER_GRAVITY,
        OFFER_MOVE
    } state_t;

    localparam logic [TELEMETRY_VALUE_WIDTH-1:0] TEL_MAX = '1;

    state_t                             state_q, state_d;
    logic                               prev_valid_q;
    logic                               spi_clear_q;
    active_piece_t                      new_piece_q, new_piece_d;
    logic                               tick_pending_q, tick_pending_d;
    logic [TELEMETRY_VALUE_WIDTH-1:0]   overflow_q, overflow_d;
    logic [TELEMETRY_VALUE_WIDTH-1:0]   missed_q, missed_d;
    logic                               cmd_is_gravity_q, cmd_is_gravity_d;
    command_t                           cmd_move_q, cmd_move_d;

    logic     capture, push, pop, xfer, gravity_xfer;
    logic     fifo_full, fifo_empty;
    command_t fifo_head;
    logic     unused_reserved;

    assign unused_reserved = ^spi_data[7:6];

    assign capture      = spi_data_valid && !prev_valid_q;
    assign push         = capture && spi_data[5];
    assign cmd_valid    = (state_q != IDLE);
    assign xfer         = cmd_valid && cmd_ready;
    assign pop          = xfer && (state_q == OFFER_MOVE);
    assign gravity_xfer = xfer && (state_q == OFFER_GRAVITY);

    move_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(command_t))
    ) u_move_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (spi_data[1:0]),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // The payload is latched on leaving IDLE so it cannot change while offered.
    always_comb begin
        state_d          = state_q;
        cmd_is_gravity_d = cmd_is_gravity_q;
        cmd_move_d       = cmd_move_q;
        case (state_q)
            IDLE: begin
                if (tick_pending_q) begin
                    state_d          = OFFER_GRAVITY;
                    cmd_is_gravity_d = 1'b1;
                end else if (!fifo_empty) begin
                    state_d          = OFFER_MOVE;
                    cmd_is_gravity_d = 1'b0;
                    cmd_move_d       = fifo_head;
                end
            end
            OFFER_GRAVITY, OFFER_MOVE: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        new_piece_d    = new_piece_q;
        overflow_d     = overflow_q;
        missed_d       = missed_q;
        tick_pending_d = gravity_xfer ? game_tick : (tick_pending_q || game_tick);
        if (capture) begin
            new_piece_d = decode_piece(spi_data[4:2]);
        end
        if (push && fifo_full && !pop && (overflow_q != TEL_MAX)) begin
            overflow_d = overflow_q + 1'b1;
        end
        if (game_tick && tick_pending_q && !gravity_xfer && (missed_q != TEL_MAX)) begin
            missed_d = missed_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            prev_valid_q     <= 1'b1;
            spi_clear_q      <= 1'b0;
            new_piece_q      <= HERO;
            tick_pending_q   <= 1'b0;
            overflow_q       <= '0;
            missed_q         <= '0;
            cmd_is_gravity_q <= 1'b0;
            cmd_move_q       <= '0;
        end else begin
            state_q          <= state_d;
            prev_valid_q     <= spi_data_valid;
            spi_clear_q      <= capture;
            new_piece_q      <= new_piece_d;
            tick_pending_q   <= tick_pending_d;
            overflow_q       <= overflow_d;
            missed_q         <= missed_d;
            cmd_is_gravity_q <= cmd_is_gravity_d;
            cmd_move_q       <= cmd_move_d;
        end
    end

    assign spi_clear         = spi_clear_q;
    assign new_piece         = new_piece_q;
    assign cmd_is_gravity    = cmd_is_gravity_q;
    assign cmd_move          = cmd_move_q;
    assign overflow_count    = overflow_q;
    assign missed_tick_count = missed_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;
    import tetris_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        spi_data;
    logic              spi_data_valid;
    logic              spi_clear;
    logic              game_tick;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_is_gravity;
    command_t          cmd_move;
    active_piece_t     new_piece;
    logic [2:0]        fifo_count;
    logic [TW-1:0]     overflow_count;
    logic [TW-1:0]     missed_tick_count;

    move_scheduler #(
        .FIFO_DEPTH            (DEPTH),
        .TELEMETRY_VALUE_WIDTH (TW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .spi_data          (spi_data),
        .spi_data_valid    (spi_data_valid),
        .spi_clear         (spi_clear),
        .game_tick         (game_tick),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_is_gravity    (cmd_is_gravity),
        .cmd_move          (cmd_move),
        .new_piece         (new_piece),
        .fifo_count        (fifo_count),
        .overflow_count    (overflow_count),
        .missed_tick_count (missed_tick_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          grav;
        command_t      mv;
    } exp_t;

    typedef struct {
        logic [7:0]    data;
        logic          queued;
        active_piece_t piece;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: transfers, post-transfer bubble, and stability under backpressure.
    logic     prev_xfer = 1'b0;
    logic     prev_stall = 1'b0;
    logic     st_grav;
    command_t st_move;
    always @(negedge clk) begin
        if (reset) begin
            prev_xfer  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_xfer) check("bubble", cmd_valid, 0);
            if (prev_stall) begin
                check("hold_valid", cmd_valid, 1);
                check("hold_payload", {cmd_is_gravity, cmd_move}, {st_grav, st_move});
            end
            if (cmd_valid && cmd_ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got grav=%0d move=%0d expected no transfer", cmd_is_gravity, cmd_move);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("xfer_is_gravity", cmd_is_gravity, e.grav);
                    if (!e.grav) check("xfer_move", cmd_move, e.mv);
                end
            end
            prev_xfer  = cmd_valid && cmd_ready;
            prev_stall = cmd_valid && !cmd_ready;
            st_grav    = cmd_is_gravity;
            st_move    = cmd_move;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input active_piece_t piece);
        next_cycle();
        spi_data       = b;
        spi_data_valid = 1'b1;
        next_cycle();
        @(negedge clk);
        check("spi_clear_pulse", spi_clear, 1);
        check("new_piece", new_piece, piece);
        next_cycle();
        spi_data_valid = 1'b0;
        @(negedge clk);
        check("spi_clear_once", spi_clear, 0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) next_cycle();
        repeat (2) next_cycle();
        check("drain_empty", sb.size(), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{8'h21, 1'b1, HERO};
        vecs[1] = '{8'h29, 1'b1, TEEWEE};
        vecs[2] = '{8'h06, 1'b0, SMASH_BOY};
        vecs[3] = '{8'h3F, 1'b1, HERO};
        vecs[4] = '{8'hD2, 1'b0, BLUE_RICKY};
        vecs[5] = '{8'h34, 1'b1, RHODE_ISLAND_Z};
        vecs[6] = '{8'h38, 1'b1, CLEVELAND_Z};
        vecs[7] = '{8'h0C, 1'b0, ORANGE_RICKY};
        vecs[8] = '{8'hE2, 1'b1, HERO};

        // Reset with a byte held valid across it: it must not be captured afterwards.
        reset = 1'b1; spi_data = 8'h2A; spi_data_valid = 1'b1; game_tick = 1'b0; cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_spi_clear", spi_clear, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow_count, 0);
        check("rst_missed", missed_tick_count, 0);
        check("rst_new_piece", new_piece, HERO);
        check("rst_is_gravity", cmd_is_gravity, 0);
        check("rst_cmd_move", cmd_move, 0);
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            check("held_byte_no_clear", spi_clear, 0);
            check("held_byte_no_push", fifo_count, 0);
        end
        next_cycle();
        spi_data_valid = 1'b0;
        repeat (2) next_cycle();

        // Single move latency: edge in N, clear in N+1, command offered and taken in N+2.
        sb.push_back('{1'b0, 2'd1});
        spi_data = 8'h21; spi_data_valid = 1'b1;
        next_cycle();
        @(negedge clk);
        check("lat_clear_n1", spi_clear, 1);
        check("lat_valid_n1", cmd_valid, 0);
        check("lat_count_n1", fifo_count, 1);
        next_cycle();
        spi_data_valid = 1'b0;
        @(negedge clk);
        check("lat_valid_n2", cmd_valid, 1);
        check("lat_grav_n2", cmd_is_gravity, 0);
        check("lat_move_n2", cmd_move, 1);
        check("lat_clear_n2", spi_clear, 0);
        check("lat_piece", new_piece, HERO);
        drain(10);

        // Table of bytes with ready held high.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].queued) sb.push_back('{1'b0, vecs[i].data[1:0]});
            send_byte(vecs[i].data, vecs[i].piece);
            repeat (2) next_cycle();
        end
        drain(20);
        check("table_fifo_empty", fifo_count, 0);

        // Gravity beats a queued move; second move arrives behind it.
        sb.push_back('{1'b1, 2'd0});
        sb.push_back('{1'b0, 2'd0});
        sb.push_back('{1'b0, 2'd1});
        next_cycle();
        spi_data = 8'h20; spi_data_valid = 1'b1; game_tick = 1'b1;
        next_cycle();
        spi_data_valid = 1'b0; game_tick = 1'b0;
        next_cycle();
        spi_data = 8'h21; spi_data_valid = 1'b1;
        next_cycle();
        spi_data_valid = 1'b0;
        @(negedge clk);
        check("prio_fifo_two", fifo_count, 2);
        drain(20);

        // Overflow: four queued, two dropped, then drained in order.
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'h20 + 8'(i % 4);
            if (i < 4) sb.push_back('{1'b0, b[1:0]});
            send_byte(b, HERO);
        end
        check("ovf_fifo_count", fifo_count, 4);
        check("ovf_overflow", overflow_count, 2);
        next_cycle();
        cmd_ready = 1'b1;
        drain(30);

        // Missed ticks while gravity is stalled, then saturation of the counter.
        cmd_ready = 1'b0;
        sb.push_back('{1'b1, 2'd0});
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            game_tick = 1'b1;
            next_cycle();
            game_tick = 1'b0;
            if (i == 2) begin
                @(negedge clk);
                check("missed_two", missed_tick_count, 2);
            end
        end
        @(negedge clk);
        check("missed_saturated", missed_tick_count, 3);
        check("missed_grav_offered", cmd_is_gravity, 1);
        next_cycle();
        cmd_ready = 1'b1;
        drain(20);

        // Backpressure on move 3 while a piece-only byte changes the spawn piece.
        cmd_ready = 1'b0;
        sb.push_back('{1'b0, 2'd3});
        send_byte(8'h2B, TEEWEE);
        repeat (2) next_cycle();
        send_byte(8'h1C, HERO);
        repeat (2) next_cycle();
        @(negedge clk);
        check("bp_valid", cmd_valid, 1);
        check("bp_move", cmd_move, 3);
        check("bp_not_queued", fifo_count, 1);
        next_cycle();
        cmd_ready = 1'b1;
        drain(20);

        // Reset during an offer abandons everything.
        cmd_ready = 1'b0;
        send_byte(8'h21, HERO);
        send_byte(8'h22, HERO);
        send_byte(8'h23, HERO);
        @(negedge clk);
        check("mid_fifo_three", fifo_count, 3);
        check("mid_offering", cmd_valid, 1);
        begin
            int saved;
            saved = xfers;
            next_cycle();
            reset = 1'b1;
            next_cycle();
            reset = 1'b0;
            @(negedge clk);
            check("mid_rst_valid", cmd_valid, 0);
            check("mid_rst_fifo", fifo_count, 0);
            check("mid_rst_overflow", overflow_count, 0);
            check("mid_rst_missed", missed_tick_count, 0);
            next_cycle();
            cmd_ready = 1'b1;
            repeat (10) next_cycle();
            check("mid_rst_no_xfer", xfers, saved);
        end

        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
